ram_arbiter: RTL and testbench

//  Shares the single-port RAM between three requesters: program loader (LDR), data port

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arb_tag_pipe.sv | 36 +++
 rtl/ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and defaults for the RAM arbiter
package ram_arbiter_pkg;

    // Requester identifiers; REQ_NONE marks an idle cycle.
    typedef enum logic [1:0] {
        REQ_LDR  = 2'd0,
        REQ_DAT  = 2'd1,
        REQ_INS  = 2'd2,
        REQ_NONE = 2'd3
    } req_id_e;

    // Bus ownership: shared arbitration or locked to the loader.
    typedef enum logic {
        OWN_SHARED = 1'b0,
        OWN_LDR    = 1'b1
    } owner_e;

    // One entry of the read-return tracking pipe.
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;

    localparam int RAM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/ram_arb_tag_pipe.sv
// rtl/ram_arb_tag_pipe.sv - read-return tag shift register matching the RAM latency
//
// Ports:
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low clear (drops in-flight reads)
//   push     in   tag for this cycle's access ({1,id} on a granted read, else invalid)
//   pop      out  tag of the read whose data is on the RAM output this cycle
module ram_arb_tag_pipe
    import ram_arbiter_pkg::*;
#(
    parameter int DEPTH = RAM_LAT_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  tag_t push,
    output tag_t pop
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '{valid: 1'b0, id: REQ_LDR};
            end
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter for loader, data port and instruction fetch
//
// Ports:
//   Clk, Reset                         clock, asynchronous active-low reset
//   Ldr_Req/Lock/We/Addr/Wdata -> Ldr_Gnt, Ldr_Rvalid   program loader (can lock the bus)
//   Dat_Req/We/Addr/Wdata      -> Dat_Gnt, Dat_Rvalid   controller data port
//   Ins_Req/Addr               -> Ins_Gnt, Ins_Rvalid   instruction fetch (read-only)
//   Rdata                      shared read data (Mem_Rdata passed through)
//   Mem_En/We/Addr/Wdata       RAM access, one per cycle
//   Mem_Rdata                  RAM read data, RAM_LAT cycles after a read strobe
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int RAM_LAT    = RAM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Ldr_Req,
    input  logic              Ldr_Lock,
    input  logic              Ldr_We,
    input  logic [ADDR_W-1:0] Ldr_Addr,
    input  logic [DATA_W-1:0] Ldr_Wdata,
    output logic              Ldr_Gnt,
    output logic              Ldr_Rvalid,
    input  logic              Dat_Req,
    input  logic              Dat_We,
    input  logic [ADDR_W-1:0] Dat_Addr,
    input  logic [DATA_W-1:0] Dat_Wdata,
    output logic              Dat_Gnt,
    output logic              Dat_Rvalid,
    input  logic              Ins_Req,
    input  logic [ADDR_W-1:0] Ins_Addr,
    output logic              Ins_Gnt,
    output logic              Ins_Rvalid,
    output logic [DATA_W-1:0] Rdata,
    output logic              Mem_En,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Wdata,
    input  logic [DATA_W-1:0] Mem_Rdata
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    owner_e              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [DATA_W-1:0]   last_wdata_q;

    req_id_e             winner;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                ins_promoted;
    tag_t                push_tag, pop_tag;

    assign ins_promoted = (starve_q >= STARVE_LIM);

    // Winner selection and the matching RAM request. Reset gates everything so
    // no grant can leak out while Reset is low even though requests are live.
    always_comb begin
        winner    = REQ_NONE;
        sel_we    = 1'b0;
        sel_addr  = last_addr_q;
        sel_wdata = last_wdata_q;

        if (Reset) begin
            if (owner_q == OWN_LDR) begin
                if (Ldr_Req) winner = REQ_LDR;
            end else if (Ldr_Req) begin
                winner = REQ_LDR;
            end else if (ins_promoted && Ins_Req) begin
                winner = REQ_INS;
            end else if (Dat_Req) begin
                winner = REQ_DAT;
            end else if (Ins_Req) begin
                winner = REQ_INS;
            end
        end

        unique case (winner)
            REQ_LDR: begin
                sel_we    = Ldr_We;
                sel_addr  = Ldr_Addr;
                sel_wdata = Ldr_Wdata;
            end
            REQ_DAT: begin
                sel_we    = Dat_We;
                sel_addr  = Dat_Addr;
                sel_wdata = Dat_Wdata;
            end
            REQ_INS: begin
                // Fetch carries no write data; the write-data bus keeps its last value.
                sel_addr  = Ins_Addr;
            end
            default: ;
        endcase
    end

    // Owner lock: taken by a locked loader grant, released the first cycle
    // Ldr_Lock is seen low (so the other ports win from the following cycle).
    always_comb begin
        owner_d = owner_q;
        unique case (owner_q)
            OWN_SHARED: if (winner == REQ_LDR && Ldr_Lock) owner_d = OWN_LDR;
            OWN_LDR:    if (!Ldr_Lock) owner_d = OWN_SHARED;
            default:    owner_d = OWN_SHARED;
        endcase
    end

    // Starvation counter for fetch; saturates so promotion persists until served.
    always_comb begin
        starve_d = '0;
        if (Ins_Req && winner != REQ_INS) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            owner_q      <= OWN_SHARED;
            starve_q     <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (winner != REQ_NONE) begin
                last_addr_q  <= sel_addr;
                last_wdata_q <= sel_wdata;
            end
        end
    end

    always_comb begin
        push_tag.valid = (winner != REQ_NONE) && !sel_we;
        push_tag.id    = winner;
    end

    ram_arb_tag_pipe #(
        .DEPTH (RAM_LAT)
    ) u_tag_pipe (
        .clk    (Clk),
        .resetn (Reset),
        .push   (push_tag),
        .pop    (pop_tag)
    );

    assign Ldr_Gnt    = (winner == REQ_LDR);
    assign Dat_Gnt    = (winner == REQ_DAT);
    assign Ins_Gnt    = (winner == REQ_INS);

    assign Mem_En     = (winner != REQ_NONE);
    assign Mem_We     = Mem_En && sel_we;
    assign Mem_Addr   = sel_addr;
    assign Mem_Wdata  = sel_wdata;

    assign Ldr_Rvalid = pop_tag.valid && (pop_tag.id == REQ_LDR);
    assign Dat_Rvalid = pop_tag.valid && (pop_tag.id == REQ_DAT);
    assign Ins_Rvalid = pop_tag.valid && (pop_tag.id == REQ_INS);
    assign Rdata      = Mem_Rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter at RAM latencies 1, 2 and 3
module tb_ram_arbiter;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        ldr_req, ldr_lock, ldr_we, dat_req, dat_we, ins_req;
    logic [7:0]  ldr_addr, dat_addr, ins_addr;
    logic [15:0] ldr_wdata, dat_wdata;

    logic        ldr_gnt [3], ldr_rvalid [3], dat_gnt [3], dat_rvalid [3];
    logic        ins_gnt [3], ins_rvalid [3], mem_en [3], mem_we [3];
    logic [7:0]  mem_addr [3];
    logic [15:0] mem_wdata [3], rdata [3], mem_rdata [3];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // Three arbiters share the stimulus; instance g runs with RAM_LAT = g+1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [15:0] ram [256];
        logic [15:0] pipe [4];

        ram_arbiter #(
            .ADDR_W(8), .DATA_W(16), .RAM_LAT(g + 1), .STARVE_MAX(4)
        ) dut (
            .Clk(Clk), .Reset(Reset),
            .Ldr_Req(ldr_req), .Ldr_Lock(ldr_lock), .Ldr_We(ldr_we),
            .Ldr_Addr(ldr_addr), .Ldr_Wdata(ldr_wdata),
            .Ldr_Gnt(ldr_gnt[g]), .Ldr_Rvalid(ldr_rvalid[g]),
            .Dat_Req(dat_req), .Dat_We(dat_we), .Dat_Addr(dat_addr), .Dat_Wdata(dat_wdata),
            .Dat_Gnt(dat_gnt[g]), .Dat_Rvalid(dat_rvalid[g]),
            .Ins_Req(ins_req), .Ins_Addr(ins_addr),
            .Ins_Gnt(ins_gnt[g]), .Ins_Rvalid(ins_rvalid[g]),
            .Rdata(rdata[g]),
            .Mem_En(mem_en[g]), .Mem_We(mem_we[g]), .Mem_Addr(mem_addr[g]),
            .Mem_Wdata(mem_wdata[g]), .Mem_Rdata(mem_rdata[g])
        );

        // RAM model: contents reload to the power-on image while Reset is low.
        always @(posedge Clk) begin
            if (!Reset) begin
                for (int a = 0; a < 256; a++) ram[a] <= init_word(8'(a));
            end else if (mem_en[g]) begin
                if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
                else           pipe[0] <= ram[mem_addr[g]];
            end
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[g];
    end

    // Behavioural model: arbitration rules plus a due-cycle return scoreboard.
    int          cyc = 0;
    int          m_owner = 0, m_starve = 0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wdata = 16'h0000;
    logic [15:0] gold [256];
    bit          pv [3][8];
    int          pid [3][8];
    logic [15:0] pdata [3][8];

    initial begin : compare
        int w, s;
        logic e_we;
        logic [7:0] e_addr;
        logic [15:0] e_wdata;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                m_owner = 0; m_starve = 0; m_addr = 8'h00; m_wdata = 16'h0000;
                for (int a = 0; a < 256; a++) gold[a] = init_word(8'(a));
                for (int g = 0; g < 3; g++) begin
                    for (int k = 0; k < 8; k++) pv[g][k] = 1'b0;
                    chk("rst_gnt", g, {ldr_gnt[g], dat_gnt[g], ins_gnt[g]}, 0);
                    chk("rst_rvalid", g, {ldr_rvalid[g], dat_rvalid[g], ins_rvalid[g]}, 0);
                    chk("rst_mem_en_we", g, {mem_en[g], mem_we[g]}, 0);
                    chk("rst_mem_addr", g, mem_addr[g], 0);
                    chk("rst_mem_wdata", g, mem_wdata[g], 0);
                end
            end else begin
                // 0 none, 1 loader, 2 data, 3 fetch
                if (m_owner != 0)                     w = ldr_req ? 1 : 0;
                else if (ldr_req)                     w = 1;
                else if (m_starve >= 4 && ins_req)    w = 3;
                else if (dat_req)                     w = 2;
                else if (ins_req)                     w = 3;
                else                                  w = 0;
                e_we    = (w == 1) ? ldr_we : (w == 2) ? dat_we : 1'b0;
                e_addr  = (w == 1) ? ldr_addr : (w == 2) ? dat_addr : (w == 3) ? ins_addr : m_addr;
                e_wdata = (w == 1) ? ldr_wdata : (w == 2) ? dat_wdata : m_wdata;
                s = cyc % 8;
                for (int g = 0; g < 3; g++) begin
                    chk("ldr_gnt", g, ldr_gnt[g], w == 1);
                    chk("dat_gnt", g, dat_gnt[g], w == 2);
                    chk("ins_gnt", g, ins_gnt[g], w == 3);
                    chk("mem_en", g, mem_en[g], w != 0);
                    chk("mem_we", g, mem_we[g], e_we);
                    chk("mem_addr", g, mem_addr[g], e_addr);
                    chk("mem_wdata", g, mem_wdata[g], e_wdata);
                    chk("ldr_rvalid", g, ldr_rvalid[g], pv[g][s] && pid[g][s] == 1);
                    chk("dat_rvalid", g, dat_rvalid[g], pv[g][s] && pid[g][s] == 2);
                    chk("ins_rvalid", g, ins_rvalid[g], pv[g][s] && pid[g][s] == 3);
                    if (pv[g][s]) chk("rdata", g, rdata[g], pdata[g][s]);
                    pv[g][s] = 1'b0;
                end
                if (w != 0 && !e_we) begin
                    for (int g = 0; g < 3; g++) begin
                        pv[g][(cyc + g + 1) % 8]    = 1'b1;
                        pid[g][(cyc + g + 1) % 8]   = w;
                        pdata[g][(cyc + g + 1) % 8] = gold[e_addr];
                    end
                end
                if (w != 0 && e_we) gold[e_addr] = e_wdata;
                m_owner  = (m_owner != 0) ? int'(ldr_lock) : int'(w == 1 && ldr_lock);
                m_starve = (ins_req && w != 3) ? ((m_starve < 4) ? m_starve + 1 : 4) : 0;
                if (w != 0) m_addr = e_addr;
                if (w == 1 || w == 2) m_wdata = e_wdata;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ldr_req = 0; ldr_lock = 0; ldr_we = 0; ldr_addr = 8'h00; ldr_wdata = 16'h0000;
        dat_req = 0; dat_we = 0; dat_addr = 8'h00; dat_wdata = 16'h0000;
        ins_req = 0; ins_addr = 8'h00;
    endtask

    initial begin : stim
        int n_l, n_d, n_rv;
        bit exp_d [6];
        bit exp_i [6];
        exp_d = '{1, 1, 1, 1, 0, 1};
        exp_i = '{0, 0, 0, 0, 1, 0};

        // 1: all requests high during reset, loader wins first cycle after release
        idle();
        Reset = 1'b0;
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'hF0; ldr_wdata = 16'h1234;
        dat_req = 1; dat_addr = 8'h20; ins_req = 1; ins_addr = 8'h40;
        repeat (2) begin
            @(negedge Clk);
            chk("t1_rst_no_gnt", 0, {ldr_gnt[0], dat_gnt[0], ins_gnt[0]}, 0);
            chk("t1_rst_mem_en", 0, mem_en[0], 0);
        end
        tick(); Reset = 1'b1;
        @(negedge Clk);
        chk("t1_ldr_first", 0, {ldr_gnt[0], dat_gnt[0], ins_gnt[0]}, 3'b100);
        tick(); idle();

        // 2: data read of 0x10 returns BEEF one cycle later on the data port only
        tick(); dat_req = 1; dat_addr = 8'h10;
        @(negedge Clk); chk("t2_dat_gnt", 0, dat_gnt[0], 1);
        tick(); dat_req = 0;
        @(negedge Clk);
        chk("t2_dat_rvalid", 0, dat_rvalid[0], 1);
        chk("t2_rdata", 0, rdata[0], 16'hBEEF);
        chk("t2_other_rvalid", 0, {ldr_rvalid[0], ins_rvalid[0]}, 0);
        repeat (3) tick();

        // 3: fetch starved four cycles, promoted on the fifth
        dat_req = 1; dat_addr = 8'h20; ins_req = 1; ins_addr = 8'h40;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("t3_dat_gnt", 0, dat_gnt[0], exp_d[i]);
            chk("t3_ins_gnt", 0, ins_gnt[0], exp_i[i]);
            tick();
        end
        idle();
        repeat (4) tick();

        // 4: locked loader burst excludes the data port until the lock drops
        n_l = 0; n_d = 0;
        dat_req = 1; dat_addr = 8'h30;
        for (int i = 0; i < 4; i++) begin
            ldr_req = 1; ldr_lock = 1; ldr_we = 1;
            ldr_addr = 8'(i); ldr_wdata = 16'hA000 + 16'(i);
            @(negedge Clk);
            n_l += int'(ldr_gnt[0]); n_d += int'(dat_gnt[0]);
            tick();
        end
        chk("t4_ldr_gnt_count", 0, n_l, 4);
        chk("t4_dat_gnt_count", 0, n_d, 0);
        ldr_req = 0; ldr_lock = 0;
        @(negedge Clk);
        chk("t4_dat_held_off", 0, {dat_gnt[0], mem_en[0]}, 0);
        tick();
        @(negedge Clk); chk("t4_dat_after_unlock", 0, dat_gnt[0], 1);
        tick(); idle();
        repeat (4) tick();

        // 5: latency 3, interleaved fetch/data reads return in issue order
        ins_req = 1; ins_addr = 8'h01;
        tick(); ins_req = 0; dat_req = 1; dat_addr = 8'h02;
        tick(); dat_req = 0; ins_req = 1; ins_addr = 8'h03;
        tick(); idle();
        @(negedge Clk);
        chk("t5_n3_ins_rvalid", 2, {ins_rvalid[2], dat_rvalid[2]}, 2'b10);
        chk("t5_n3_rdata", 2, rdata[2], 16'hA001);
        tick();
        @(negedge Clk);
        chk("t5_n4_dat_rvalid", 2, {ins_rvalid[2], dat_rvalid[2]}, 2'b01);
        chk("t5_n4_rdata", 2, rdata[2], 16'hA002);
        tick();
        @(negedge Clk);
        chk("t5_n5_ins_rvalid", 2, {ins_rvalid[2], dat_rvalid[2]}, 2'b10);
        chk("t5_n5_rdata", 2, rdata[2], 16'hA003);
        repeat (4) tick();

        // 6: reset one cycle after a granted read drops the return
        dat_req = 1; dat_addr = 8'h10;
        @(negedge Clk); chk("t6_dat_gnt", 1, dat_gnt[1], 1);
        tick(); dat_req = 0; Reset = 1'b0;
        @(negedge Clk); chk("t6_rst_rvalid", 1, dat_rvalid[1], 0);
        tick(); Reset = 1'b1;
        n_rv = 0;
        repeat (4) begin
            @(negedge Clk);
            for (int g = 0; g < 3; g++)
                n_rv += int'(ldr_rvalid[g]) + int'(dat_rvalid[g]) + int'(ins_rvalid[g]);
            tick();
        end
        chk("t6_no_rvalid_after_release", 1, n_rv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
